// File: rtl/key_expand.sv
// One AES-128 key-schedule round: next round key from current key and Rcon index; optional rc_err via KEY_EXPAND_RC_CHECK_EN.
// Latency: 1 cycle (registered keyout/valid), one result per start edge.
// Backpressure: none; every start edge produces a result.
module key_expand (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       rc,
  input  logic [15:0][7:0] key,
  output logic [15:0][7:0] keyout,
`ifdef KEY_EXPAND_RC_CHECK_EN
  output logic             rc_err,
`endif
  output logic             valid
);

  // FIPS-197 forward S-box, entry 0 in the most significant byte, so lookup uses ~index.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [31:0]       w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
  logic [15:0][7:0]  keyout_d, keyout_q;
  logic              valid_q;

  // Column words are gathered row0-first from the state-matrix byte layout.
  assign w0   = {key[15], key[11], key[7], key[3]};
  assign w1   = {key[14], key[10], key[6], key[2]};
  assign w2   = {key[13], key[9],  key[5], key[1]};
  assign w3   = {key[12], key[8],  key[4], key[0]};
  assign rot  = {w3[23:0], w3[31:24]};
  assign sub  = {SBOX[~rot[31:24]], SBOX[~rot[23:16]], SBOX[~rot[15:8]], SBOX[~rot[7:0]]};
  assign temp = sub ^ {rcon(rc), 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = n0 ^ w1;
  assign n2   = n1 ^ w2;
  assign n3   = n2 ^ w3;
  assign keyout_d = {n0[31:24], n1[31:24], n2[31:24], n3[31:24],
                     n0[23:16], n1[23:16], n2[23:16], n3[23:16],
                     n0[15:8],  n1[15:8],  n2[15:8],  n3[15:8],
                     n0[7:0],   n1[7:0],   n2[7:0],   n3[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyout_q <= '0;
      valid_q  <= 1'b0;
    end else if (start) begin
      keyout_q <= keyout_d;
      valid_q  <= 1'b1;
    end else begin
      valid_q  <= 1'b0;
    end
  end

  assign keyout = keyout_q;
  assign valid  = valid_q;

`ifdef KEY_EXPAND_RC_CHECK_EN
  logic rc_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_err_q <= 1'b0;
    end else begin
      rc_err_q <= start && (rc > 4'd9);
    end
  end

  assign rc_err = rc_err_q;
`endif

endmodule

// File: tb/tb_key_expand.sv
// Directed bench for key_expand using FIPS-197 AES-128 key-schedule vectors.
module tb_key_expand;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       rc;
  logic [15:0][7:0] key;
  logic [15:0][7:0] keyout;
  logic             valid;
`ifdef KEY_EXPAND_RC_CHECK_EN
  logic             rc_err;
`endif

  int checks = 0;
  int errors = 0;

  key_expand dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rc     (rc),
    .key    (key),
    .keyout (keyout),
`ifdef KEY_EXPAND_RC_CHECK_EN
    .rc_err (rc_err),
`endif
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column words (row0 first) into the state-matrix byte layout.
  function automatic logic [127:0] mk(input logic [31:0] a, b, c, d);
    mk = {a[31:24], b[31:24], c[31:24], d[31:24],
          a[23:16], b[23:16], c[23:16], d[23:16],
          a[15:8],  b[15:8],  c[15:8],  d[15:8],
          a[7:0],   b[7:0],   c[7:0],   d[7:0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] fips_key, rk1, rk9, rk10, zero_r1, zero_r2, sub63;

  initial begin
    fips_key = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    rk1      = mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605);
    rk9      = mk(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e);
    rk10     = mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
    zero_r1  = mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363);
    zero_r2  = mk(32'h9b9898c9, 32'hf9fbfbaa, 32'h9b9898c9, 32'hf9fbfbaa);
    sub63    = mk(32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363);

    rst = 1'b1; start = 1'b0; rc = 4'd0; key = '0;
    #2;
    check("reset_keyout", keyout, 128'h0);
    check("reset_valid", {127'h0, valid}, 128'h0);
    tick(); tick();
    rst = 1'b0;

    // Layout sanity on the bench helper itself against the stated byte positions
    key = fips_key;
    check("fips_key_byte15", {120'h0, key[15]}, 128'h2b);
    check("fips_key_byte0", {120'h0, key[0]}, 128'h3c);

    start = 1'b1; rc = 4'd0;
    tick();
    start = 1'b0; key = '0; rc = 4'd5;
    check("fips_r1_valid", {127'h0, valid}, 128'h1);
    check("fips_r1_key", keyout, rk1);
    check("fips_r1_byte14", {120'h0, keyout[14]}, 128'h88);
    tick();
    check("hold_valid", {127'h0, valid}, 128'h0);
    check("hold_key", keyout, rk1);
    tick();
    check("hold2_key", keyout, rk1);

    key = '0; rc = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_r1_key", keyout, zero_r1);
    key = zero_r1; rc = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_r2_key", keyout, zero_r2);
    check("zero_r2_valid", {127'h0, valid}, 128'h1);

    key = rk9; rc = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    check("rcon36_key", keyout, rk10);

    // Back-to-back chain through all ten rounds
    key = fips_key; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rc = i[3:0];
      tick();
      check($sformatf("chain_valid_%0d", i), {127'h0, valid}, 128'h1);
      if (i == 0) check("chain_r1", keyout, rk1);
      if (i == 8) check("chain_r9", keyout, rk9);
      key = keyout;
    end
    start = 1'b0;
    check("chain_r10", keyout, rk10);
    tick();
    check("chain_end_valid", {127'h0, valid}, 128'h0);

    // Reset pulsed between edges in the middle of a chain
    key = fips_key; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rc = i[3:0];
      tick();
      key = keyout;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_keyout", keyout, 128'h0);
    check("midrst_valid", {127'h0, valid}, 128'h0);
    start = 1'b0;
    tick();
    check("rst_held_keyout", keyout, 128'h0);
    rst = 1'b0;
    tick();
    check("post_rst_idle_valid", {127'h0, valid}, 128'h0);
    check("post_rst_idle_keyout", keyout, 128'h0);
    key = fips_key; rc = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_first_valid", {127'h0, valid}, 128'h1);
    check("post_rst_first_key", keyout, rk1);

    // Out-of-range round index falls back to Rcon 00
    key = '0; rc = 4'hA; start = 1'b1;
    tick();
    check("rc_a_key", keyout, sub63);
`ifdef KEY_EXPAND_RC_CHECK_EN
    check("rc_a_err", {127'h0, rc_err}, 128'h1);
`endif
    rc = 4'd0;
    tick();
    start = 1'b0;
    check("rc_0_key", keyout, zero_r1);
`ifdef KEY_EXPAND_RC_CHECK_EN
    check("rc_0_err", {127'h0, rc_err}, 128'h0);
`endif
    rc = 4'hF; start = 1'b1; key = '0;
    tick();
    start = 1'b0;
    check("rc_f_key", keyout, sub63);
`ifdef KEY_EXPAND_RC_CHECK_EN
    check("rc_f_err", {127'h0, rc_err}, 128'h1);
    tick();
    check("rc_idle_err", {127'h0, rc_err}, 128'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
